// File: rtl/clk_div_lock_pkg.sv
// Shared types and helpers for the clock-enable generator with lock sequencing.
package clk_div_lock_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } lock_state_e;

  // Settle counter must hold LOCK_CYCLES itself without wrapping.
  function automatic int settle_cnt_width(input int lock_cycles);
    int w;
    w = $clog2(lock_cycles + 1);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: wrapping counter, enable strobe and 50%-duty toggle clock.
module clk_div_chan
  import clk_div_lock_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             resetn,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] d,
  output logic             stb,
  output logic             ch_clk
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] last_s;
  logic             clk_r;

  // Terminal count; a ratio of zero behaves as a ratio of one.
  always_comb begin
    last_s = {CNT_W{1'b0}};
    if (d == {CNT_W{1'b0}}) begin
      last_s = {CNT_W{1'b0}};
    end else begin
      last_s = d - CNT_W'(1);
    end
  end

  // Strobe is combinational from registers so it lines up with the counter.
  always_comb begin
    stb = 1'b0;
    if (en && (cnt_r == last_s)) begin
      stb = 1'b1;
    end else begin
      stb = 1'b0;
    end
  end

  // Counter wraps at the terminal count; the output clock flips on every strobe.
  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      cnt_r <= {CNT_W{1'b0}};
      clk_r <= 1'b0;
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
      clk_r <= 1'b0;
    end else if (en) begin
      cnt_r <= stb ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
      clk_r <= stb ? ~clk_r : clk_r;
    end else begin
      cnt_r <= cnt_r;
      clk_r <= clk_r;
    end
  end

  assign ch_clk = clk_r;

endmodule

// File: rtl/clk_div_lock_gen.sv
// Clock-enable generator with OFF/SETTLE/LOCKED sequencing and runtime divide ratios.
// Optional reference-activity watchdog enabled by defining CLK_LOCK_MON_EN.
module clk_div_lock_gen
  import clk_div_lock_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 16,
  parameter int LOCK_CYCLES = 100,
  parameter int MON_TIMEOUT = 1024
) (
  input  logic                    clk_in,
  input  logic                    resetn,
  input  logic                    pwr_dn,
  input  logic                    cfg_load,
  input  logic [NUM_CH*CNT_W-1:0] div_cfg,
  input  logic                    ref_tick,
  output logic                    locked,
  output logic [NUM_CH-1:0]       ch_stb,
  output logic [NUM_CH-1:0]       ch_clk,
  output logic                    lock_lost
);

  localparam int SC_W = settle_cnt_width(LOCK_CYCLES);

  lock_state_e               state_r;
  lock_state_e               next_state_s;
  logic [SC_W-1:0]           settle_cnt_r;
  logic [NUM_CH*CNT_W-1:0]   div_q_r;
  logic                      locked_r;
  logic                      load_s;
  logic                      restart_s;
  logic                      wd_fire_s;
  logic                      chan_clr_s;

  // Next-state decode; pwr_dn overrides everything, cfg_load beats the watchdog.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    if (pwr_dn) begin
      next_state_s = ST_OFF;
    end else begin
      case (state_r)
        ST_OFF: begin
          next_state_s = ST_SETTLE;
          load_s       = 1'b1;
        end
        ST_SETTLE: begin
          if (cfg_load) begin
            next_state_s = ST_SETTLE;
            load_s       = 1'b1;
          end else if (settle_cnt_r == SC_W'(LOCK_CYCLES - 1)) begin
            next_state_s = ST_LOCKED;
          end else begin
            next_state_s = ST_SETTLE;
          end
        end
        ST_LOCKED: begin
          if (cfg_load) begin
            next_state_s = ST_SETTLE;
            load_s       = 1'b1;
          end else if (wd_fire_s) begin
            next_state_s = ST_SETTLE;
          end else begin
            next_state_s = ST_LOCKED;
          end
        end
        default: begin
          next_state_s = ST_OFF;
        end
      endcase
    end
  end

  // Any fresh entry into SETTLE (or a reload while in it) restarts the settle count.
  always_comb begin
    restart_s = 1'b0;
    if ((next_state_s == ST_SETTLE) && (load_s || (state_r != ST_SETTLE))) begin
      restart_s = 1'b1;
    end else begin
      restart_s = 1'b0;
    end
  end

  // Channels are held cleared outside LOCKED and on every edge entering or leaving it.
  always_comb begin
    chan_clr_s = 1'b1;
    if ((state_r == ST_LOCKED) && (next_state_s == ST_LOCKED)) begin
      chan_clr_s = 1'b0;
    end else begin
      chan_clr_s = 1'b1;
    end
  end

  // State, settle counter, captured ratios and lock flag.
  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_OFF;
      settle_cnt_r <= {SC_W{1'b0}};
      div_q_r      <= {(NUM_CH*CNT_W){1'b0}};
      locked_r     <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      locked_r <= (next_state_s == ST_LOCKED);
      div_q_r  <= load_s ? div_cfg : div_q_r;
      if (restart_s) begin
        settle_cnt_r <= {SC_W{1'b0}};
      end else if (next_state_s == ST_SETTLE) begin
        settle_cnt_r <= settle_cnt_r + SC_W'(1);
      end else begin
        settle_cnt_r <= {SC_W{1'b0}};
      end
    end
  end

`ifdef CLK_LOCK_MON_EN
  localparam int WD_W = $clog2(MON_TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt_r;
  logic            lock_lost_r;
  logic            cfg_take_s;

  assign cfg_take_s = cfg_load && !pwr_dn && (state_r != ST_OFF);

  // Watchdog fires on the cycle the idle count would reach MON_TIMEOUT.
  always_comb begin
    wd_fire_s = 1'b0;
    if ((state_r == ST_LOCKED) && !ref_tick && (wd_cnt_r == WD_W'(MON_TIMEOUT - 1))) begin
      wd_fire_s = 1'b1;
    end else begin
      wd_fire_s = 1'b0;
    end
  end

  // Idle counter runs only while staying LOCKED; lock_lost is sticky until a reload.
  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      wd_cnt_r    <= {WD_W{1'b0}};
      lock_lost_r <= 1'b0;
    end else begin
      if ((state_r == ST_LOCKED) && (next_state_s == ST_LOCKED)) begin
        wd_cnt_r <= ref_tick ? {WD_W{1'b0}} : wd_cnt_r + WD_W'(1);
      end else begin
        wd_cnt_r <= {WD_W{1'b0}};
      end
      if (cfg_take_s) begin
        lock_lost_r <= 1'b0;
      end else if (wd_fire_s) begin
        lock_lost_r <= 1'b1;
      end else begin
        lock_lost_r <= lock_lost_r;
      end
    end
  end

  assign lock_lost = lock_lost_r;
`else
  logic [1:0] mon_unused_s;

  assign mon_unused_s = {ref_tick, (MON_TIMEOUT > 0)};
  assign wd_fire_s    = 1'b0;
  assign lock_lost    = 1'b0;
`endif

  assign locked = locked_r;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk_in (clk_in),
      .resetn (resetn),
      .clr    (chan_clr_s),
      .en     (locked_r),
      .d      (div_q_r[i*CNT_W +: CNT_W]),
      .stb    (ch_stb[i]),
      .ch_clk (ch_clk[i])
    );
  end

endmodule

// File: tb/tb_clk_div_lock_gen.sv
// Self-checking bench for clk_div_lock_gen; outputs are predicted from lock time and ratio arithmetic.
module tb_clk_div_lock_gen;

  localparam int NUM_CH      = 2;
  localparam int CNT_W       = 16;
  localparam int LOCK_CYCLES = 100;
`ifdef CLK_LOCK_MON_EN
  localparam int MON_TIMEOUT = 16;
`else
  localparam int MON_TIMEOUT = 1024;
`endif

  logic                    clk_in;
  logic                    resetn;
  logic                    pwr_dn;
  logic                    cfg_load;
  logic [NUM_CH*CNT_W-1:0] div_cfg;
  logic                    ref_tick;
  logic                    locked;
  logic [NUM_CH-1:0]       ch_stb;
  logic [NUM_CH-1:0]       ch_clk;
  logic                    lock_lost;

  clk_div_lock_gen #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .LOCK_CYCLES(LOCK_CYCLES), .MON_TIMEOUT(MON_TIMEOUT)
  ) dut (
    .clk_in(clk_in), .resetn(resetn), .pwr_dn(pwr_dn), .cfg_load(cfg_load),
    .div_cfg(div_cfg), .ref_tick(ref_tick), .locked(locked), .ch_stb(ch_stb),
    .ch_clk(ch_clk), .lock_lost(lock_lost)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Reference model state: SETTLE entry cycle, power/lock enable, captured ratios.
  int  ent;
  bit  on;
  int  mdiv [NUM_CH];
  int  cur  [NUM_CH];
  int  pend;
  bit  exp_lost;
  bit  tick_en;
  int  tick_p;
  int  checks;
  int  errors;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic void model(input int c, output logic l,
                                output logic [NUM_CH-1:0] s, output logic [NUM_CH-1:0] k);
    int t;
    int d;
    t = ent + LOCK_CYCLES;
    l = on && (c >= t);
    s = '0;
    k = '0;
    if (l) begin
      for (int i = 0; i < NUM_CH; i++) begin
        d    = (mdiv[i] == 0) ? 1 : mdiv[i];
        s[i] = (((c - t) % d) == d - 1);
        k[i] = (((c - t) / d) % 2) == 1;
      end
    end
  endfunction

  task automatic step();
    logic              l;
    logic [NUM_CH-1:0] s;
    logic [NUM_CH-1:0] k;
    @(negedge clk_in);
    if (ref_tick) tick_p = cyc;
    if (pend >= 0 && cyc >= pend) begin
      ent      = pend;
      pend     = -1;
      exp_lost = 1'b1;
    end
    model(cyc, l, s, k);
    chk("locked", 8'(locked), 8'(l));
    chk("ch_stb", 8'(ch_stb), 8'(s));
    chk("ch_clk", 8'(ch_clk), 8'(k));
    chk("lock_lost", 8'(lock_lost), 8'(exp_lost));
    ref_tick = tick_en && ((cyc % 10) == 9);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic set_div(input int d0, input int d1);
    cur[0]  = d0;
    cur[1]  = d1;
    div_cfg = {CNT_W'(d1), CNT_W'(d0)};
  endtask

  task automatic load(input int d0, input int d1);
    set_div(d0, d1);
    cfg_load = 1'b1;
    ent      = cyc + 1;
    mdiv     = cur;
    exp_lost = 1'b0;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    #2;
    resetn = 1'b0;
    #1;
    chk({tag, "_locked"}, 8'(locked), 8'h00);
    chk({tag, "_stb"}, 8'(ch_stb), 8'h00);
    chk({tag, "_clk"}, 8'(ch_clk), 8'h00);
    chk({tag, "_lost"}, 8'(lock_lost), 8'h00);
    on       = 1'b0;
    exp_lost = 1'b0;
    run(3);
    resetn = 1'b1;
    ent    = cyc + 1;
    on     = 1'b1;
    mdiv   = cur;
  endtask

  initial begin
    checks = 0; errors = 0;
    resetn = 1'b0; pwr_dn = 1'b1; cfg_load = 1'b0; div_cfg = '0; ref_tick = 1'b0;
    on = 1'b0; ent = 0; pend = -1; exp_lost = 1'b0; tick_en = 1'b1; tick_p = 0;
    cur = '{0, 0}; mdiv = '{0, 0};
    #1;
    chk("rst_locked", 8'(locked), 8'h00);
    chk("rst_stb", 8'(ch_stb), 8'h00);
    chk("rst_clk", 8'(ch_clk), 8'h00);
    chk("rst_lost", 8'(lock_lost), 8'h00);
    repeat (3) @(negedge clk_in);
    resetn = 1'b1;
    run(3);

    // Power up with ratios {2,5}.
    set_div(2, 5);
    pwr_dn = 1'b0; on = 1'b1; ent = cyc + 1; mdiv = cur;
    run(LOCK_CYCLES + 30);

    // Ratio change without cfg_load must not alter the outputs.
    set_div(9, 4);
    run(25);

    // Reload with {3,7} while locked.
    load(3, 7);
    run(LOCK_CYCLES + 30);

    // Ratios 0 and 1 both give a permanent strobe.
    load(0, 1);
    run(LOCK_CYCLES + 10);

    // Random ratios.
    for (int r = 0; r < 3; r++) begin
      load(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
      run(LOCK_CYCLES + 25);
    end

    // pwr_dn together with cfg_load: power-down wins.
    set_div(4, 6);
    pwr_dn = 1'b1; cfg_load = 1'b1; on = 1'b0;
    step();
    cfg_load = 1'b0;
    run(5);
    pwr_dn = 1'b0; on = 1'b1; ent = cyc + 1; mdiv = cur;
    run(LOCK_CYCLES + 20);

    // Async reset while locked, then while settling.
    async_reset("arst_lock");
    run(50);
    async_reset("arst_settle");
    run(LOCK_CYCLES + 20);

`ifdef CLK_LOCK_MON_EN
    // Stop reference ticks: watchdog drops lock and sets the sticky flag.
    run(40);
    tick_en  = 1'b0;
    ref_tick = 1'b0;
    pend     = ((tick_p > ent + LOCK_CYCLES) ? tick_p : ent + LOCK_CYCLES) + MON_TIMEOUT;
    run(MON_TIMEOUT + 5);
    tick_en = 1'b1;
    run(LOCK_CYCLES + 20);
    load(2, 3);
    run(LOCK_CYCLES + 10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
